// File: rtl/enc_pkg.sv
// enc_pkg: homing FSM states, step codes and the quadrature step decoder
// shared by the encoder controller.
package enc_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_ARMED, ST_HOMED} home_st_e;

    typedef enum logic [1:0] {STEP_NONE, STEP_FWD, STEP_REV, STEP_ILL} step_e;

    // Forward order of {A,B} is 00 -> 10 -> 11 -> 01 -> 00.
    function automatic step_e decode_step(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] nxt;
        nxt = (prev == 2'b00) ? 2'b10 : (prev == 2'b10) ? 2'b11 : (prev == 2'b11) ? 2'b01 : 2'b00;
        return (prev == cur) ? STEP_NONE : ((prev ^ cur) == 2'b11) ? STEP_ILL : (cur == nxt) ? STEP_FWD : STEP_REV;
    endfunction

endpackage

// File: rtl/quad_enc_ctrl_if.sv
// quad_enc_ctrl_if: encoder channels, commands and status of the quadrature
// encoder controller.
interface quad_enc_ctrl_if #(
    parameter int CNT_W = 16,
    parameter int WIN_W = 16
);
    logic                    enc_a;
    logic                    enc_b;
    logic                    enc_z;
    logic                    cmd_home;
    logic                    cmd_clear;
    logic [WIN_W-1:0]        win_len;
    logic signed [CNT_W-1:0] position;
    logic                    dir;
    logic                    homed;
    logic signed [CNT_W-1:0] speed;
    logic                    spd_valid;
    logic                    err;

    modport master (
        output enc_a, enc_b, enc_z, cmd_home, cmd_clear, win_len,
        input  position, dir, homed, speed, spd_valid, err
    );

    modport slave (
        input  enc_a, enc_b, enc_z, cmd_home, cmd_clear, win_len,
        output position, dir, homed, speed, spd_valid, err
    );
endinterface

// File: rtl/enc_sync.sv
// enc_sync: 2-flop synchronizer for one raw encoder channel plus a
// rising-edge flag; all flops come out of reset at 1.
module enc_sync (
    input  logic clock,
    input  logic reset,
    input  logic d_i,
    output logic q_o,
    output logic rise_o
);
    logic [2:0] sh_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) sh_q <= '1;
        else        sh_q <= {sh_q[1:0], d_i};
    end

    assign q_o    = sh_q[1];
    assign rise_o = sh_q[1] & ~sh_q[2];
endmodule

// File: rtl/quad_enc_ctrl.sv
// quad_enc_ctrl: quadrature decoder with signed position, index homing FSM
// and windowed speed measurement.
module quad_enc_ctrl import enc_pkg::*; #(
    parameter int CNT_W = 16,
    parameter int WIN_W = 16
) (
    input logic           clock,
    input logic           reset,
    quad_enc_ctrl_if.slave bus
);
    logic a_s, b_s, z_s_unused, z_rise, a_rise_unused, b_rise_unused;
    logic [1:0]              ab_q;
    logic [1:0]              st_q;
    step_e                   step;
    logic signed [CNT_W-1:0] delta, pos_q, pos_d, acc_q, spd_q, sum_sat;
    logic signed [CNT_W:0]   sum;
    logic                    dir_q, err_q, vld_q, homed_q, home_load, win_end;
    home_st_e                hs_q;
    logic [WIN_W-1:0]        cnt_q, len_q, len_e;

    enc_sync u_sync_a (.clock(clock), .reset(reset), .d_i(bus.enc_a), .q_o(a_s), .rise_o(a_rise_unused));
    enc_sync u_sync_b (.clock(clock), .reset(reset), .d_i(bus.enc_b), .q_o(b_s), .rise_o(b_rise_unused));
    enc_sync u_sync_z (.clock(clock), .reset(reset), .d_i(bus.enc_z), .q_o(z_s_unused), .rise_o(z_rise));

    // The synchronizers hold their reset value for two clocks, so the first
    // real sample is loaded on the third edge and decoding starts after that.
    assign step      = (st_q == 2'd3) ? decode_step(ab_q, {a_s, b_s}) : STEP_NONE;
    assign delta     = (step == STEP_FWD) ? CNT_W'(1) : (step == STEP_REV) ? '1 : '0;
    assign home_load = (hs_q == ST_ARMED) && z_rise && !bus.cmd_home;
    assign pos_d     = (bus.cmd_clear || home_load) ? '0 : pos_q + delta;

    assign sum     = {acc_q[CNT_W-1], acc_q} + {delta[CNT_W-1], delta};
    assign sum_sat = (sum[CNT_W] != sum[CNT_W-1]) ? {sum[CNT_W], {(CNT_W-1){~sum[CNT_W]}}} : sum[CNT_W-1:0];
    // Window length is only taken from the port when a window starts.
    assign len_e   = (cnt_q == '0) ? bus.win_len : len_q;
    assign win_end = (len_e != '0) && (cnt_q == len_e - WIN_W'(1));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ab_q  <= '0;
            st_q  <= '0;
            pos_q <= '0;
            dir_q <= 1'b0;
            err_q <= 1'b0;
            cnt_q <= '0;
            len_q <= '0;
            acc_q <= '0;
            spd_q <= '0;
            vld_q <= 1'b0;
        end else begin
            ab_q  <= {a_s, b_s};
            st_q  <= (st_q == 2'd3) ? st_q : st_q + 2'd1;
            pos_q <= pos_d;
            dir_q <= (step == STEP_FWD) ? 1'b1 : (step == STEP_REV) ? 1'b0 : dir_q;
            err_q <= err_q | (step == STEP_ILL);
            len_q <= len_e;
            vld_q <= win_end;
            if (len_e == '0) begin
                cnt_q <= '0;
                acc_q <= '0;
            end else if (win_end) begin
                cnt_q <= '0;
                acc_q <= '0;
                spd_q <= sum_sat;
            end else begin
                cnt_q <= cnt_q + WIN_W'(1);
                acc_q <= sum_sat;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hs_q    <= ST_IDLE;
            homed_q <= 1'b0;
        end else if (bus.cmd_home) begin
            hs_q    <= ST_ARMED;
            homed_q <= 1'b0;
        end else if (home_load) begin
            hs_q    <= ST_HOMED;
            homed_q <= 1'b1;
        end
    end

    assign bus.position  = pos_q;
    assign bus.dir       = dir_q;
    assign bus.homed     = homed_q;
    assign bus.speed     = spd_q;
    assign bus.spd_valid = vld_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_quad_enc_ctrl.sv
// tb_quad_enc_ctrl: directed scenarios for quad_enc_ctrl with hand-computed
// expectations; inputs change and outputs are sampled on the falling edge.
module tb_quad_enc_ctrl;
    logic clock;
    logic reset;
    int   total;
    int   bad;
    int   cyc;
    int   pq[$];
    logic signed [15:0] sq[$];
    logic [1:0] ab;

    quad_enc_ctrl_if #(.CNT_W(16), .WIN_W(16)) bus ();

    quad_enc_ctrl #(.CNT_W(16), .WIN_W(16)) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        cyc++;
        if (bus.spd_valid === 1'b1) begin
            pq.push_back(cyc);
            sq.push_back(bus.speed);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [1:0] nxt_fwd(input logic [1:0] p);
        return (p == 2'b00) ? 2'b10 : (p == 2'b10) ? 2'b11 : (p == 2'b11) ? 2'b01 : 2'b00;
    endfunction

    function automatic logic [1:0] nxt_rev(input logic [1:0] p);
        return (p == 2'b00) ? 2'b01 : (p == 2'b01) ? 2'b11 : (p == 2'b11) ? 2'b10 : 2'b00;
    endfunction

    task automatic set_ab(input logic [1:0] v);
        ab = v;
        bus.enc_a = v[1];
        bus.enc_b = v[0];
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic fwd(input int gap);
        set_ab(nxt_fwd(ab));
        wait_clk(gap);
    endtask

    task automatic rev(input int gap);
        set_ab(nxt_rev(ab));
        wait_clk(gap);
    endtask

    task automatic pulse_clear;
        bus.cmd_clear = 1'b1;
        wait_clk(1);
        bus.cmd_clear = 1'b0;
    endtask

    task automatic pulse_home;
        bus.cmd_home = 1'b1;
        wait_clk(1);
        bus.cmd_home = 1'b0;
    endtask

    task automatic test_reset;
        wait_clk(3);
        total++; if (bus.position !== 16'h0000) begin bad++; $display("FAIL rst_pos got=%h exp=0000", bus.position); end
        total++; if (bus.dir !== 1'b0) begin bad++; $display("FAIL rst_dir got=%b exp=0", bus.dir); end
        total++; if (bus.homed !== 1'b0) begin bad++; $display("FAIL rst_homed got=%b exp=0", bus.homed); end
        total++; if (bus.speed !== 16'h0000) begin bad++; $display("FAIL rst_speed got=%h exp=0000", bus.speed); end
        total++; if (bus.spd_valid !== 1'b0) begin bad++; $display("FAIL rst_vld got=%b exp=0", bus.spd_valid); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", bus.err); end
        reset = 1'b1;
        wait_clk(6);
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL start_err got=%b exp=0", bus.err); end
        total++; if (bus.position !== 16'h0000) begin bad++; $display("FAIL start_pos got=%h exp=0000", bus.position); end
    endtask

    task automatic test_forward;
        set_ab(nxt_fwd(ab));
        wait_clk(2);
        total++; if (bus.position !== 16'h0000) begin bad++; $display("FAIL lat_early got=%h exp=0000", bus.position); end
        wait_clk(1);
        total++; if (bus.position !== 16'h0001) begin bad++; $display("FAIL lat_k2 got=%h exp=0001", bus.position); end
        wait_clk(1);
        repeat (7) fwd(4);
        total++; if (bus.position !== 16'h0008) begin bad++; $display("FAIL fwd_pos got=%h exp=0008", bus.position); end
        total++; if (bus.dir !== 1'b1) begin bad++; $display("FAIL fwd_dir got=%b exp=1", bus.dir); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL fwd_err got=%b exp=0", bus.err); end
    endtask

    task automatic test_reverse;
        pulse_clear();
        wait_clk(2);
        total++; if (bus.position !== 16'h0000) begin bad++; $display("FAIL clear_pos got=%h exp=0000", bus.position); end
        fwd(4);
        total++; if (bus.position !== 16'h0001) begin bad++; $display("FAIL rev_start got=%h exp=0001", bus.position); end
        repeat (3) rev(4);
        total++; if (bus.position !== 16'hFFFE) begin bad++; $display("FAIL rev_pos got=%h exp=fffe", bus.position); end
        total++; if (bus.dir !== 1'b0) begin bad++; $display("FAIL rev_dir got=%b exp=0", bus.dir); end
    endtask

    task automatic test_illegal;
        set_ab(ab ^ 2'b11);
        wait_clk(4);
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL ill_err got=%b exp=1", bus.err); end
        total++; if (bus.position !== 16'hFFFE) begin bad++; $display("FAIL ill_pos got=%h exp=fffe", bus.position); end
        total++; if (bus.dir !== 1'b0) begin bad++; $display("FAIL ill_dir got=%b exp=0", bus.dir); end
        repeat (10) fwd(4);
        total++; if (bus.err !== 1'b1) begin bad++; $display("FAIL ill_sticky got=%b exp=1", bus.err); end
        total++; if (bus.position !== 16'h0008) begin bad++; $display("FAIL ill_after got=%h exp=0008", bus.position); end
    endtask

    task automatic test_home;
        total++; if (bus.homed !== 1'b0) begin bad++; $display("FAIL home_pre got=%b exp=0", bus.homed); end
        pulse_home();
        repeat (5) fwd(4);
        total++; if (bus.position !== 16'h000D) begin bad++; $display("FAIL home_steps got=%h exp=000d", bus.position); end
        total++; if (bus.homed !== 1'b0) begin bad++; $display("FAIL home_armed got=%b exp=0", bus.homed); end
        bus.enc_z = 1'b1;
        fwd(4);
        total++; if (bus.position !== 16'h0000) begin bad++; $display("FAIL home_pos got=%h exp=0000", bus.position); end
        total++; if (bus.homed !== 1'b1) begin bad++; $display("FAIL home_done got=%b exp=1", bus.homed); end
        bus.enc_z = 1'b0;
        wait_clk(4);
        repeat (2) fwd(4);
        bus.enc_z = 1'b1;
        wait_clk(4);
        bus.enc_z = 1'b0;
        wait_clk(4);
        total++; if (bus.position !== 16'h0002) begin bad++; $display("FAIL home_zignore got=%h exp=0002", bus.position); end
        total++; if (bus.homed !== 1'b1) begin bad++; $display("FAIL home_keep got=%b exp=1", bus.homed); end
        pulse_home();
        wait_clk(2);
        total++; if (bus.homed !== 1'b0) begin bad++; $display("FAIL rearm got=%b exp=0", bus.homed); end
        fwd(4);
        bus.enc_z = 1'b1;
        wait_clk(2);
        pulse_clear();
        wait_clk(3);
        total++; if (bus.position !== 16'h0000) begin bad++; $display("FAIL clr_home_pos got=%h exp=0000", bus.position); end
        total++; if (bus.homed !== 1'b1) begin bad++; $display("FAIL clr_home_st got=%b exp=1", bus.homed); end
        bus.enc_z = 1'b0;
        wait_clk(4);
    endtask

    task automatic test_speed;
        pq.delete();
        sq.delete();
        bus.win_len = 16'd100;
        repeat (35) fwd(10);
        total++; if (pq.size() !== 3) begin bad++; $display("FAIL spd_count got=%0d exp=3", pq.size()); end
        if (pq.size() == 3) begin
            total++; if (pq[1] - pq[0] !== 100) begin bad++; $display("FAIL spd_gap1 got=%0d exp=100", pq[1] - pq[0]); end
            total++; if (pq[2] - pq[1] !== 100) begin bad++; $display("FAIL spd_gap2 got=%0d exp=100", pq[2] - pq[1]); end
            for (int i = 0; i < 3; i++) begin
                total++; if (sq[i] !== 16'sd10) begin bad++; $display("FAIL spd_val%0d got=%0d exp=10", i, sq[i]); end
            end
        end
        bus.win_len = 16'd0;
        repeat (11) fwd(10);
        pq.delete();
        sq.delete();
        repeat (30) fwd(10);
        total++; if (pq.size() !== 0) begin bad++; $display("FAIL spd_off got=%0d exp=0", pq.size()); end
        total++; if (bus.speed !== 16'sd10) begin bad++; $display("FAIL spd_hold got=%0d exp=10", bus.speed); end
    endtask

    task automatic test_wrap;
        pulse_clear();
        wait_clk(2);
        pq.delete();
        sq.delete();
        bus.win_len = 16'd40000;
        repeat (32767) begin
            set_ab(nxt_fwd(ab));
            wait_clk(1);
        end
        wait_clk(3);
        total++; if (bus.position !== 16'h7FFF) begin bad++; $display("FAIL wrap_max got=%h exp=7fff", bus.position); end
        fwd(4);
        total++; if (bus.position !== 16'h8000) begin bad++; $display("FAIL wrap_min got=%h exp=8000", bus.position); end
        total++; if (bus.dir !== 1'b1) begin bad++; $display("FAIL wrap_dir got=%b exp=1", bus.dir); end
        for (int i = 0; i < 10000 && pq.size() == 0; i++) wait_clk(1);
        bus.win_len = 16'd0;
        total++; if (pq.size() !== 1) begin bad++; $display("FAIL sat_pulse got=%0d exp=1", pq.size()); end
        total++; if (bus.speed !== 16'sh7FFF) begin bad++; $display("FAIL sat_speed got=%h exp=7fff", bus.speed); end
        wait_clk(2);
    endtask

    task automatic test_reset_mid;
        pq.delete();
        sq.delete();
        bus.win_len = 16'd100;
        repeat (5) fwd(10);
        reset = 1'b0;
        #1;
        total++; if (bus.position !== 16'h0000) begin bad++; $display("FAIL mid_pos got=%h exp=0000", bus.position); end
        total++; if (bus.dir !== 1'b0) begin bad++; $display("FAIL mid_dir got=%b exp=0", bus.dir); end
        total++; if (bus.homed !== 1'b0) begin bad++; $display("FAIL mid_homed got=%b exp=0", bus.homed); end
        total++; if (bus.speed !== 16'h0000) begin bad++; $display("FAIL mid_speed got=%h exp=0000", bus.speed); end
        total++; if (bus.spd_valid !== 1'b0) begin bad++; $display("FAIL mid_vld got=%b exp=0", bus.spd_valid); end
        total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL mid_err got=%b exp=0", bus.err); end
        wait_clk(60);
        reset = 1'b1;
        wait_clk(50);
        total++; if (pq.size() !== 0) begin bad++; $display("FAIL mid_nopulse got=%0d exp=0", pq.size()); end
        wait_clk(60);
        total++; if (pq.size() !== 1) begin bad++; $display("FAIL mid_restart got=%0d exp=1", pq.size()); end
        bus.win_len = 16'd0;
    endtask

    initial begin
        total = 0;
        bad = 0;
        clock = 1'b0;
        reset = 1'b0;
        bus.enc_z = 1'b0;
        bus.cmd_home = 1'b0;
        bus.cmd_clear = 1'b0;
        bus.win_len = '0;
        set_ab(2'b00);
        test_reset();
        test_forward();
        test_reverse();
        test_illegal();
        test_home();
        test_speed();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/quad_enc_ctrl.md
QUAD_ENC_CTRL -- requirements
Module: quad_enc_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of position and speed registers (signed two's complement).
REQ-002 SHALL have parameter WIN_W, default 16, width of speed-window length.
REQ-003 SHALL have port clock  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports enc_a, enc_b, enc_z  input  1 each  raw asynchronous encoder channels A, B and index Z.
REQ-006 SHALL have port cmd_home  input  1  one-cycle pulse: arm homing on next Z rising edge.
REQ-007 SHALL have port cmd_clear  input  1  one-cycle pulse: zero position immediately.
REQ-008 SHALL have port win_len  input  WIN_W  speed window length in clocks; 0 disables speed.
REQ-009 SHALL have port position  output  CNT_W  signed quadrature position count.
REQ-010 SHALL have port dir  output  1  direction of last valid step (1 forward, 0 reverse).
REQ-011 SHALL have port homed  output  1  high once homing has completed.
REQ-012 SHALL have port speed  output  CNT_W  signed net step count of the last completed window.
REQ-013 SHALL have port spd_valid  output  1  one-cycle pulse when speed is updated.
REQ-014 SHALL have port err  output  1  sticky flag: illegal transition seen.

Function
REQ-015 SHALL pass A, B and Z through a 2-flop synchronizer each; a change meeting setup before edge k is decoded at edge k+2, so position changes at the output after edge k+2.
REQ-016 SHALL decode {A,B}: forward 00->10->11->01->00 gives +1 and dir=1; the reverse sequence gives -1 and dir=0; no change gives 0.
REQ-017 SHALL treat a change of both bits in one sample as illegal: position and dir unchanged, err set until reset.
REQ-018 SHALL, on the first sample after reset release, load the previous-state register without decoding (no step, no err).
REQ-019 SHALL wrap position modulo 2^CNT_W (max +1 -> min; min -1 -> max).
REQ-020 SHALL implement homing FSM states IDLE (reset), ARMED, HOMED; cmd_home in any state -> ARMED and homed=0; in ARMED, synchronized Z rising edge -> position=0, homed=1, state HOMED; Z is ignored in IDLE and HOMED.
REQ-021 SHALL apply priority per cycle: cmd_clear or home-load (position=0) over decoded step; a step in that cycle is discarded from position but still counted in speed.
REQ-022 SHALL, when cmd_clear and home-load coincide, result in position=0 and state HOMED; cmd_clear never changes FSM state.
REQ-023 SHALL, when win_len!=0, count clocks 0..win_len-1; at count win_len-1 load speed with window accumulator plus that cycle's step, pulse spd_valid, and restart with accumulator 0.
REQ-024 SHALL saturate the window accumulator at signed CNT_W limits.
REQ-025 SHALL sample win_len only at window start; win_len=0 holds speed, suppresses spd_valid, and keeps the window counter and accumulator at 0.
REQ-026 SHALL update speed independently of cmd_clear and homing.

Reset
REQ-027 SHALL on reset low asynchronously set position=0, dir=0, homed=0, speed=0, spd_valid=0, err=0, FSM=IDLE, window counter and accumulator 0, synchronizer flops 1, first-sample flag cleared.
REQ-028 SHALL, when reset is asserted mid-window or mid-homing, abandon the operation with no spd_valid pulse.

Structure
REQ-029 SHALL put FSM state encoding and the forward/reverse/illegal step codes in shared package enc_pkg.
REQ-030 SHALL instantiate sub-module enc_sync (2-flop synchronizer plus rising-edge flag, reset to 1) once per channel A, B, Z.

Verification
REQ-031 SHALL cover: after reset with A=B=0, drive 8 forward steps, 4 clocks apart -> no err, position=8, dir=1.
REQ-032 SHALL cover: at position=1, drive 3 reverse steps -> position=-2 (0xFFFE at CNT_W=16), dir=0.
REQ-033 SHALL cover: A and B toggled in the same clock -> err=1 and position unchanged; err stays set through 10 further valid steps.
REQ-034 SHALL cover: cmd_home, 5 steps, then Z rising together with a forward step -> position=0, homed=1; a further Z pulse changes nothing.
REQ-035 SHALL cover: win_len=100 with a forward step every 10 clocks -> spd_valid every 100 clocks with speed=10; set win_len=0 -> no further spd_valid and speed holds 10.
REQ-036 SHALL cover: position=0x7FFF plus one forward step -> 0x8000; reset asserted mid-window -> all outputs 0 and no spd_valid.
